ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Iterative RV32M divide unit on the EX side of the ID/EX pipeline register. Consumes the registered instruction and operands the ID/EX register drives into EX.
- Executes DIV, DIVU, REM and REMU over multiple cycles. Requests a pipeline stall so the ID/EX register contents stay frozen while it computes.
- Returns the quotient or remainder with its write-back address and enable for the EX result mux.

Parameters:
- XLEN, 32, operand and result width; the RV32 value is the only supported setting.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- ex_inst  input  32  instruction held in ID/EX
- ex_s_op1  input  32  rs1 value (dividend)
- ex_s_op2  input  32  rs2 value (divisor)
- ex_reg_waddr  input  5  destination register
- ex_reg_we  input  1  destination write enable
- flush  input  1  annul the in-flight instruction (branch/exception)
- div_stall_req  output  1  hold ID/EX and earlier stages
- div_done  output  1  one-cycle pulse; result valid this cycle
- div_result  output  32  quotient or remainder
- div_reg_waddr  output  5  latched ex_reg_waddr
- div_reg_we  output  1  latched ex_reg_we, qualified by div_done

Behaviour:
- Decode: is_div = opcode 7'b0110011 and funct7 7'b0000001 and funct3[2] = 1.
  - funct3 100 is DIV, 101 is DIVU, 110 is REM, 111 is REMU.
  - Every other instruction is ignored.
- States: IDLE, BUSY, DONE.
- Reset (rst=1 at a clk edge): state goes to IDLE and the counter to 0. div_done, div_result, div_reg_waddr and div_reg_we are all 0. div_stall_req is forced to 0 while rst=1.
- IDLE:
  - div_stall_req = is_div & ~flush, combinational from the ID/EX outputs.
  - On an edge with is_div and no flush, latch op type, waddr and we.
  - Divisor = 0: go directly to DONE. Quotient = 32'hFFFFFFFF, remainder = dividend.
  - Signed op with dividend 32'h80000000 and divisor 32'hFFFFFFFF: go directly to DONE. Quotient = 32'h80000000, remainder = 0.
  - Otherwise latch |op1| and |op2| (raw values for unsigned ops), record the result sign, clear the counter and go to BUSY.
- BUSY:
  - div_stall_req = 1.
  - One restoring shift-subtract step per cycle on a 64-bit partial-remainder/quotient register.
  - Counter runs 0..31; after the step with count = 31, go to DONE.
- DONE:
  - div_stall_req = 0 and div_done = 1 for exactly one cycle. The result is applied to div_result at the same time.
  - Sign fix-up, signed ops only: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign.
  - The next state is IDLE unconditionally. The DONE-cycle stall release lets ID/EX advance, so the same instruction is never restarted.
- Latency, normal case:
  - Cycle T0 is the IDLE detect with stall=1. T1..T32 are BUSY. T33 is DONE with stall=0 and done=1.
  - The ID/EX register is stalled for 33 cycles.
- Latency, special cases (divide by zero, overflow): stall=1 at T0 only, done=1 at T1.
- Outputs outside DONE: div_result and div_reg_waddr hold their last value. div_done = 0 and div_reg_we = 0.
- flush, any state: the next state is IDLE, with no done pulse and no write.
  - div_stall_req drops combinationally in the same cycle flush is high.
  - flush has priority over BUSY completion and over the DONE pulse; a DONE cycle with flush=1 gives div_done=0.
- rst has priority over flush and over all other events, in any state.
- A div_reg_waddr of 0 is passed through unchanged; suppressing writes to x0 is the register file's job.
- Back-to-back div instructions: the second is detected in the IDLE cycle right after DONE.

Test Plan:
- DIVU with op1=100, op2=7 -> div_stall_req=1 for T0..T32; at T33 div_done=1, div_result=14, div_reg_we equals the latched we. A REMU repeat gives div_result=2.
- REM with op1=32'hFFFFFFF9 (-7), op2=2 -> div_result=32'hFFFFFFFF (-1). DIV with the same operands -> 32'hFFFFFFFD (-3).
- DIV with op2=0, op1=123 -> done at T1 with div_result=32'hFFFFFFFF. REM with op2=0 -> div_result=123.
- Overflow: DIV 32'h80000000 / 32'hFFFFFFFF -> result 32'h80000000 at T1. REM -> result 0.
- flush=1 at T10 of a DIVU -> stall drops at T10, state is IDLE at T11, no done pulse. Separately, rst=1 at T5 -> all outputs 0 from T6.
- ADD instruction (funct7=0) and MUL (funct3=000) presented -> div_stall_req stays 0 and div_done never pulses. Two consecutive DIVU -> two done pulses 34 cycles apart.

Source files
------------

// File: rtl/ex_div.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU) on the EX side of ID/EX.
// Restoring shift-subtract, one quotient bit per cycle, stalls ID/EX while busy.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     ex_inst,
    input  logic [XLEN-1:0] ex_s_op1,
    input  logic [XLEN-1:0] ex_s_op2,
    input  logic [4:0]      ex_reg_waddr,
    input  logic            ex_reg_we,
    input  logic            flush,
    output logic            div_stall_req,
    output logic            div_done,
    output logic [XLEN-1:0] div_result,
    output logic [4:0]      div_reg_waddr,
    output logic            div_reg_we
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = '1;

    state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   divisor_q;
    logic              rem_sel_q;
    logic              neg_quo_q;
    logic              neg_rem_q;
    logic [4:0]        waddr_q;
    logic              we_q;
    logic [XLEN-1:0]   res_q;
    logic [4:0]        out_waddr_q;

    logic              is_div;
    logic              op_signed;
    logic              div_by_zero;
    logic              overflow;
    logic [XLEN-1:0]   op1_mag;
    logic [XLEN-1:0]   op2_mag;
    logic [XLEN+1:0]   trial;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;
    logic [XLEN-1:0]   done_val;
    logic              unused_inst_bits;

    assign is_div      = (ex_inst[6:0] == 7'b0110011) && (ex_inst[31:25] == 7'b0000001) && ex_inst[14];
    assign op_signed   = ~ex_inst[12];
    assign div_by_zero = (ex_s_op2 == '0);
    assign overflow    = op_signed && (ex_s_op1 == MIN_INT) && (ex_s_op2 == ONES);
    assign op1_mag     = (op_signed && ex_s_op1[XLEN-1]) ? -ex_s_op1 : ex_s_op1;
    assign op2_mag     = (op_signed && ex_s_op2[XLEN-1]) ? -ex_s_op2 : ex_s_op2;
    assign unused_inst_bits = ^{ex_inst[24:15], ex_inst[11:7]};

    // Upper half of acc is the partial remainder, lower half shifts dividend out and quotient in
    assign trial    = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {2'b0, divisor_q};
    assign acc_step = trial[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0}
                                    : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign quo_fixed = neg_quo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fixed = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign done_val  = rem_sel_q ? rem_fixed : quo_fixed;

    always_comb begin
        state_next    = state;
        div_stall_req = 1'b0;
        div_done      = 1'b0;
        case (state)
            IDLE: begin
                if (is_div && !flush) begin
                    div_stall_req = 1'b1;
                    state_next    = (div_by_zero || overflow) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    div_stall_req = 1'b1;
                    if (cnt == CNT_W'(XLEN-1))
                        state_next = DONE;
                end
            end
            DONE: begin
                div_done   = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            div_stall_req = 1'b0;
            div_done      = 1'b0;
        end
    end

    // Special cases preload acc with the final quotient/remainder and skip the iterations
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            divisor_q   <= '0;
            rem_sel_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            waddr_q     <= '0;
            we_q        <= 1'b0;
            res_q       <= '0;
            out_waddr_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (is_div && !flush) begin
                        rem_sel_q <= ex_inst[13];
                        waddr_q   <= ex_reg_waddr;
                        we_q      <= ex_reg_we;
                        cnt       <= '0;
                        if (div_by_zero) begin
                            acc       <= {ex_s_op1, ONES};
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else if (overflow) begin
                            acc       <= {{XLEN{1'b0}}, MIN_INT};
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            acc       <= {{XLEN{1'b0}}, op1_mag};
                            divisor_q <= op2_mag;
                            neg_quo_q <= op_signed && (ex_s_op1[XLEN-1] ^ ex_s_op2[XLEN-1]);
                            neg_rem_q <= op_signed && ex_s_op1[XLEN-1];
                        end
                    end
                end
                BUSY: begin
                    if (!flush) begin
                        acc <= acc_step;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!flush) begin
                        res_q       <= done_val;
                        out_waddr_q <= waddr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result and address show the fresh values during the done pulse and hold them afterwards
    assign div_result    = div_done ? done_val : res_q;
    assign div_reg_waddr = div_done ? waddr_q : out_waddr_q;
    assign div_reg_we    = div_done & we_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, hand-written flush/reset/
// back-to-back sequences, and random operations against an arithmetic reference model.
module tb_ex_div;

    logic        clk;
    logic        rst;
    logic [31:0] ex_inst;
    logic [31:0] ex_s_op1;
    logic [31:0] ex_s_op2;
    logic [4:0]  ex_reg_waddr;
    logic        ex_reg_we;
    logic        flush;
    logic        div_stall_req;
    logic        div_done;
    logic [31:0] div_result;
    logic [4:0]  div_reg_waddr;
    logic        div_reg_we;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        logic [4:0]  wa;
        logic        we;
    } vec_t;

    vec_t vecs[14];

    ex_div dut (
        .clk          (clk),
        .rst          (rst),
        .ex_inst      (ex_inst),
        .ex_s_op1     (ex_s_op1),
        .ex_s_op2     (ex_s_op2),
        .ex_reg_waddr (ex_reg_waddr),
        .ex_reg_we    (ex_reg_we),
        .flush        (flush),
        .div_stall_req(div_stall_req),
        .div_done     (div_done),
        .div_result   (div_result),
        .div_reg_waddr(div_reg_waddr),
        .div_reg_we   (div_reg_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference model straight from the RV32M rules, using native SV division
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return f3[1] ? a : 32'hFFFFFFFF;
        if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return f3[1] ? 32'd0 : 32'h80000000;
        if (!f3[0])
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        return f3[1] ? a % b : a / b;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))
            return 1;
        return 33;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] wa, input logic we);
        ex_inst      = inst;
        ex_s_op1     = a;
        ex_s_op2     = b;
        ex_reg_waddr = wa;
        ex_reg_we    = we;
        flush        = 1'b0;
    endtask

    // Presents one instruction held in ID/EX until the done pulse (or a cycle budget runs out)
    task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] wa, input logic we,
                           output logic [31:0] res, output logic [4:0] got_wa, output logic got_we,
                           output int lat, output int stalls, output int done_cyc, output logic bad_stall);
        res = '0; got_wa = '0; got_we = 1'b0;
        lat = -1; stalls = 0; done_cyc = -1; bad_stall = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(mk_inst(7'b0000001, f3, 7'b0110011), a, b, wa, we);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (div_done) begin
                res = div_result; got_wa = div_reg_waddr; got_we = div_reg_we;
                lat = k; done_cyc = cyc;
                if (div_stall_req) bad_stall = 1'b1;
                break;
            end
            if (div_stall_req) stalls++;
            else bad_stall = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] res;
        logic [4:0]  got_wa;
        logic        got_we;
        int          lat, stalls, dcyc, dcyc1, seen;
        logic        bad;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         33, 5'd5,  1'b1};
        vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          33, 5'd6,  1'b0};
        vecs[2]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33, 5'd7,  1'b1};
        vecs[3]  = '{3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33, 5'd0,  1'b1};
        vecs[4]  = '{3'b100, 32'd123,        32'd0,          32'hFFFFFFFF,   1,  5'd8,  1'b1};
        vecs[5]  = '{3'b110, 32'd123,        32'd0,          32'd123,        1,  5'd9,  1'b1};
        vecs[6]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  5'd10, 1'b1};
        vecs[7]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  5'd11, 1'b0};
        vecs[8]  = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33, 5'd12, 1'b1};
        vecs[9]  = '{3'b111, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33, 5'd13, 1'b1};
        vecs[10] = '{3'b100, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33, 5'd14, 1'b1};
        vecs[11] = '{3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          33, 5'd31, 1'b1};
        vecs[12] = '{3'b110, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'hFFFFFFFF,   33, 5'd15, 1'b1};
        vecs[13] = '{3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33, 5'd16, 1'b1};

        // Reset with a DIV sitting in ID/EX: stall must stay low
        rst = 1'b1;
        apply_stimulus(mk_inst(7'b0000001, 3'b100, 7'b0110011), 32'd100, 32'd7, 5'd3, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_stall", {31'b0, div_stall_req}, 32'd0);
        check_output("reset_done",  {31'b0, div_done}, 32'd0);
        check_output("reset_result", div_result, 32'd0);
        check_output("reset_waddr", {27'b0, div_reg_waddr}, 32'd0);
        check_output("reset_we",    {31'b0, div_reg_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply_stimulus(NOP, 32'd0, 32'd0, 5'd0, 1'b0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].we,
                    res, got_wa, got_we, lat, stalls, dcyc, bad);
            check_output($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check_output($sformatf("vec%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].lat));
            check_output($sformatf("vec%0d_stall_shape", i), {31'b0, bad}, 32'd0);
            check_output($sformatf("vec%0d_waddr", i), {27'b0, got_wa}, {27'b0, vecs[i].wa});
            check_output($sformatf("vec%0d_we", i), {31'b0, got_we}, {31'b0, vecs[i].we});
        end

        $display("[TB] non-divide instructions");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            case (i / 10)
                0: apply_stimulus(mk_inst(7'b0000000, 3'b000, 7'b0110011), 32'd100, 32'd7, 5'd4, 1'b1);
                1: apply_stimulus(mk_inst(7'b0000000, 3'b100, 7'b0110011), 32'd100, 32'd7, 5'd4, 1'b1);
                2: apply_stimulus(mk_inst(7'b0000001, 3'b000, 7'b0110011), 32'd100, 32'd7, 5'd4, 1'b1);
                default: apply_stimulus(mk_inst(7'b0000001, 3'b101, 7'b0010011), 32'd100, 32'd7, 5'd4, 1'b1);
            endcase
            @(negedge clk);
            if (div_stall_req || div_done || div_reg_we) seen++;
        end
        check_output("nondiv_activity", 32'(seen), 32'd0);

        $display("[TB] flush at T10");
        @(posedge clk); #1;
        apply_stimulus(mk_inst(7'b0000001, 3'b101, 7'b0110011), 32'd100, 32'd7, 5'd20, 1'b1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (div_stall_req && !div_done) seen++;
            @(posedge clk); #1;
        end
        check_output("flush_pre_stall", 32'(seen), 32'd10);
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_stall_drop", {31'b0, div_stall_req}, 32'd0);
        check_output("flush_no_done", {31'b0, div_done}, 32'd0);
        run_div(3'b101, 32'd200, 32'd7, 5'd21, 1'b1, res, got_wa, got_we, lat, stalls, dcyc, bad);
        check_output("after_flush_latency", 32'(lat), 32'd33);
        check_output("after_flush_result", res, 32'd28);
        check_output("after_flush_waddr", {27'b0, got_wa}, 32'd21);

        $display("[TB] reset at T5");
        @(posedge clk); #1;
        apply_stimulus(mk_inst(7'b0000001, 3'b101, 7'b0110011), 32'd1000, 32'd3, 5'd22, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_t5_stall", {31'b0, div_stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply_stimulus(NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        check_output("rst_t6_result", div_result, 32'd0);
        check_output("rst_t6_waddr", {27'b0, div_reg_waddr}, 32'd0);
        check_output("rst_t6_we", {31'b0, div_reg_we}, 32'd0);
        check_output("rst_t6_done", {31'b0, div_done}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (div_done || div_stall_req) seen++;
        end
        check_output("rst_no_done", 32'(seen), 32'd0);

        $display("[TB] back-to-back");
        run_div(3'b101, 32'd100, 32'd7, 5'd23, 1'b1, res, got_wa, got_we, lat, stalls, dcyc1, bad);
        check_output("b2b_first_result", res, 32'd14);
        run_div(3'b101, 32'd50, 32'd5, 5'd24, 1'b1, res, got_wa, got_we, lat, stalls, dcyc, bad);
        check_output("b2b_second_result", res, 32'd10);
        check_output("b2b_spacing", 32'(dcyc - dcyc1), 32'd34);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 16));
                3: b = -32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            run_div(f3, a, b, 5'(i), 1'b1, res, got_wa, got_we, lat, stalls, dcyc, bad);
            check_output($sformatf("rand%0d_f3%0d_%h_%h", i, f3, a, b), res, ref_result(f3, a, b));
            check_output($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_latency(f3, a, b)));
        end

        @(posedge clk); #1;
        apply_stimulus(NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
